mul_div_unit: RTL

Iterative unsigned multiply/divide unit in the execute stage of the single-cycle processor. Handles the MUL/DIV class instructions the combinational ALU does not. The control unit muxes its result onto the ALU-result bus, which addresses data memory and feeds the write-back mux. The pipeline holds the PC and register-file writes while `busy` is high.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_step.sv | 44 ++++
 rtl/mul_div_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// The {hi, lo} pair is the product register for multiply and {rem, quot} for divide.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_is_div,
    input  logic [WIDTH:0]   i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH:0]   o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_trial;

    // Next {hi, lo}: multiply adds a into hi when lo[0] is set and shifts right
    // with the carry; divide shifts left and keeps the trial subtraction if it
    // did not go negative.
    always_comb begin
        w_addend = i_lo[0] ? i_opnd : '0;
        // hi is always below 2^WIDTH in multiply mode, so bit WIDTH of the sum is the carry
        w_sum    = i_hi + {1'b0, w_addend};
        // the stored remainder is always below the divisor, so its top bit is zero
        w_rem_sh = {i_hi[WIDTH-1:0], i_lo[WIDTH-1]};
        w_trial  = {1'b0, w_rem_sh} - {2'b00, i_opnd};
        o_hi     = {1'b0, w_sum[WIDTH:1]};
        o_lo     = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_is_div) begin
            if (!w_trial[WIDTH+1]) begin
                o_hi = w_trial[WIDTH:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_rem_sh;
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: fixed WIDTH+1 edge latency from
// accept to the done pulse, one datapath iteration per RUN cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    op_e              r_op;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             w_accept;
    logic             w_last;
    logic             w_is_div;
    logic [WIDTH:0]   w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_is_div = (r_op == OP_DIVU) || (r_op == OP_REMU);

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (w_is_div),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    // Next-state, accept/last-iteration strobes and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Iteration counter, cleared on accept and advanced once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst)           r_cnt <= '0;
        else if (w_accept) r_cnt <= '0;
        else if (busy)     r_cnt <= r_cnt + 1'b1;
    end

    // Operand latch and working registers; a reset leaves them stale because
    // the next accept reloads them before they are used.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= op_e'(op);
            r_hi   <= '0;
            r_lo   <= op[1] ? operand_a : operand_b;
            r_opnd <= op[1] ? operand_b : operand_a;
        end else if (busy) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

    // Result and divide-by-zero flag, written only by the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (w_last) begin
            result      <= (r_op == OP_MULHU || r_op == OP_REMU) ? w_hi_nxt[WIDTH-1:0] : w_lo_nxt;
            div_by_zero <= w_is_div && (r_opnd == '0);
        end
    end

endmodule
